// File: rtl/pong_pkg.sv
// Shared Pong definitions: score FSM states, screen/goal defaults, field widths.
package pong_pkg;

   localparam int unsigned SCREEN_W    = 640;
   localparam int unsigned X_W         = 10;
   localparam int unsigned SCORE_W     = 4;
   localparam int unsigned SERVE_CNT_W = 8;

   localparam logic [X_W-1:0] LEFT_GOAL_DEF  = 10'd2;
   localparam logic [X_W-1:0] RIGHT_GOAL_DEF = 10'd637;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SERVE,
      ST_PLAY,
      ST_POINT,
      ST_OVER
   } state_e;

   // Increment a score but never past the match limit, so BCD can never wrap.
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s,
                                                     input logic [SCORE_W-1:0] lim);
      return (s >= lim) ? lim : s + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; history resets high so a level held through reset is not an edge.
module rise_detect (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic level,
   output logic rise_c
);

   logic level_q;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) level_q <= 1'b1;
      else       level_q <= level;
   end

   assign rise_c = level & ~level_q;

endmodule

// File: rtl/score_tracker.sv
// Pong match referee: serve delay, goal detection, BCD scores and game-over.
// Optional macro SCORE_TRACKER_SERVE_BUTTON_EN: after the serve delay, wait for a start press.
module score_tracker
   import pong_pkg::*;
#(
   parameter int unsigned     WIN_SCORE    = 9,
   parameter int unsigned     SERVE_FRAMES = 60,
   parameter logic [X_W-1:0]  LEFT_GOAL    = LEFT_GOAL_DEF,
   parameter logic [X_W-1:0]  RIGHT_GOAL   = RIGHT_GOAL_DEF
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic [X_W-1:0]     ball_x,
   input  logic               ball_valid,
   input  logic               start,
   output logic               score_A,
   output logic               score_B,
   output logic [SCORE_W-1:0] score_A_bcd,
   output logic [SCORE_W-1:0] score_B_bcd,
   output logic               ball_freeze,
   output logic               serve_dir,
   output logic               game_over,
   output logic               winner
);

   localparam logic [SCORE_W-1:0]     WIN_Q      = SCORE_W'(WIN_SCORE);
   localparam logic [SERVE_CNT_W-1:0] SERVE_LOAD = SERVE_CNT_W'(SERVE_FRAMES);

   state_e                 state_q, state_d;
   logic [SERVE_CNT_W-1:0] cnt_q, cnt_d;
   logic [SCORE_W-1:0]     score_a_d, score_b_d, inc_a_c, inc_b_c;
   logic                   point_b_q, point_b_d;
   logic                   dir_d, winner_d;
   logic                   pulse_a_d, pulse_b_d, freeze_d, over_d;
   logic                   start_rise_c, goal_left_c, goal_right_c;

   rise_detect u_start_rise (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .level      (start),
      .rise_c     (start_rise_c)
   );

   // Left goal has priority if a misconfiguration makes both edges overlap.
   assign goal_left_c  = frame_tick & ball_valid & (ball_x <= LEFT_GOAL);
   assign goal_right_c = frame_tick & ball_valid & (ball_x >= RIGHT_GOAL) & ~goal_left_c;
   assign inc_a_c      = score_inc(score_A_bcd, WIN_Q);
   assign inc_b_c      = score_inc(score_B_bcd, WIN_Q);

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      score_a_d = score_A_bcd;
      score_b_d = score_B_bcd;
      point_b_d = point_b_q;
      dir_d     = serve_dir;
      winner_d  = winner;

      unique case (state_q)
         ST_IDLE: begin
            if (start_rise_c) begin
               state_d = ST_SERVE;
               cnt_d   = SERVE_LOAD;
            end
         end

         ST_SERVE: begin
`ifdef SCORE_TRACKER_SERVE_BUTTON_EN
            // Counter parked at zero means the delay expired and we await a press.
            if (cnt_q == '0) begin
               if (start_rise_c) state_d = ST_PLAY;
            end else if (frame_tick) begin
               cnt_d = cnt_q - SERVE_CNT_W'(1);
            end
`else
            if (frame_tick) begin
               if (cnt_q <= SERVE_CNT_W'(1)) begin
                  cnt_d   = '0;
                  state_d = ST_PLAY;
               end else begin
                  cnt_d = cnt_q - SERVE_CNT_W'(1);
               end
            end
`endif
         end

         ST_PLAY: begin
            if (goal_left_c) begin
               state_d   = ST_POINT;
               point_b_d = 1'b1;
               dir_d     = 1'b0;
            end else if (goal_right_c) begin
               state_d   = ST_POINT;
               point_b_d = 1'b0;
               dir_d     = 1'b1;
            end
         end

         ST_POINT: begin
            if (point_b_q) begin
               score_b_d = inc_b_c;
            end else begin
               score_a_d = inc_a_c;
            end
            if ((point_b_q ? inc_b_c : inc_a_c) == WIN_Q) begin
               state_d  = ST_OVER;
               winner_d = point_b_q;
            end else begin
               state_d = ST_SERVE;
               cnt_d   = SERVE_LOAD;
            end
         end

         ST_OVER: begin
            if (start_rise_c) begin
               state_d   = ST_SERVE;
               cnt_d     = SERVE_LOAD;
               score_a_d = '0;
               score_b_d = '0;
               dir_d     = 1'b0;
               winner_d  = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      pulse_a_d = (state_d == ST_POINT) & ~point_b_d;
      pulse_b_d = (state_d == ST_POINT) &  point_b_d;
      freeze_d  = (state_d != ST_PLAY);
      over_d    = (state_d == ST_OVER);
   end

   // State and registered outputs.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         point_b_q   <= 1'b0;
         score_A_bcd <= '0;
         score_B_bcd <= '0;
         score_A     <= 1'b0;
         score_B     <= 1'b0;
         ball_freeze <= 1'b1;
         serve_dir   <= 1'b0;
         game_over   <= 1'b0;
         winner      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         point_b_q   <= point_b_d;
         score_A_bcd <= score_a_d;
         score_B_bcd <= score_b_d;
         score_A     <= pulse_a_d;
         score_B     <= pulse_b_d;
         ball_freeze <= freeze_d;
         serve_dir   <= dir_d;
         game_over   <= over_d;
         winner      <= winner_d;
      end
   end

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed match scenarios plus random play against a match model.
module tb_score_tracker;

   localparam int unsigned WIN = 3;
   localparam int unsigned SF  = 60;
   localparam logic [9:0]  LG  = 10'd2;
   localparam logic [9:0]  RG  = 10'd637;
`ifdef SCORE_TRACKER_SERVE_BUTTON_EN
   localparam bit BTN = 1'b1;
`else
   localparam bit BTN = 1'b0;
`endif

   localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

   logic       clk_100MHz, reset, frame_tick, ball_valid, start;
   logic [9:0] ball_x;
   logic       score_A, score_B, ball_freeze, serve_dir, game_over, winner;
   logic [3:0] score_A_bcd, score_B_bcd;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   score_tracker #(
      .WIN_SCORE    (WIN),
      .SERVE_FRAMES (SF),
      .LEFT_GOAL    (LG),
      .RIGHT_GOAL   (RG)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .ball_x      (ball_x),
      .ball_valid  (ball_valid),
      .start       (start),
      .score_A     (score_A),
      .score_B     (score_B),
      .score_A_bcd (score_A_bcd),
      .score_B_bcd (score_B_bcd),
      .ball_freeze (ball_freeze),
      .serve_dir   (serve_dir),
      .game_over   (game_over),
      .winner      (winner)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Match model: where the game stands, frames left before play, scores, who is serving.
   int m_mode, m_frames, m_sa, m_sb, m_dir, m_win, m_ptb, m_prev;

   always @(posedge clk_100MHz or posedge reset) begin
      int mode, frames, sa, sb, dir, win, ptb;
      bit rise;
      if (reset) begin
         m_mode <= M_IDLE; m_frames <= 0; m_sa <= 0; m_sb <= 0;
         m_dir <= 0; m_win <= 0; m_ptb <= 0; m_prev <= 1;
      end else begin
         mode = m_mode; frames = m_frames; sa = m_sa; sb = m_sb;
         dir = m_dir; win = m_win; ptb = m_ptb;
         rise = (start == 1'b1) && (m_prev == 0);
         case (m_mode)
            M_IDLE: if (rise) begin mode = M_SERVE; frames = SF; end
            M_SERVE: begin
               if (frames == 0) begin
                  if (rise) mode = M_PLAY;
               end else if (frame_tick) begin
                  frames = frames - 1;
                  if (frames == 0 && !BTN) mode = M_PLAY;
               end
            end
            M_PLAY: begin
               if (frame_tick && ball_valid) begin
                  if (int'(ball_x) <= int'(LG)) begin mode = M_POINT; ptb = 1; dir = 0; end
                  else if (int'(ball_x) >= int'(RG)) begin mode = M_POINT; ptb = 0; dir = 1; end
               end
            end
            M_POINT: begin
               if (ptb == 1) sb = sb + 1; else sa = sa + 1;
               if (sa == WIN || sb == WIN) begin mode = M_OVER; win = ptb; end
               else begin mode = M_SERVE; frames = SF; end
            end
            default: begin
               if (rise) begin mode = M_SERVE; frames = SF; sa = 0; sb = 0; dir = 0; win = 0; end
            end
         endcase
         m_mode <= mode; m_frames <= frames; m_sa <= sa; m_sb <= sb;
         m_dir <= dir; m_win <= win; m_ptb <= ptb; m_prev <= int'(start);
      end
   end

   always @(negedge clk_100MHz) begin
      if (cmp_en) begin
         chk("cyc_freeze", int'(ball_freeze), int'(m_mode != M_PLAY));
         chk("cyc_score_A", int'(score_A), int'(m_mode == M_POINT && m_ptb == 0));
         chk("cyc_score_B", int'(score_B), int'(m_mode == M_POINT && m_ptb == 1));
         chk("cyc_bcd_A", int'(score_A_bcd), m_sa);
         chk("cyc_bcd_B", int'(score_B_bcd), m_sb);
         chk("cyc_serve_dir", int'(serve_dir), m_dir);
         chk("cyc_game_over", int'(game_over), int'(m_mode == M_OVER));
         if (m_mode == M_OVER) chk("cyc_winner", int'(winner), m_win);
      end
   end

   task automatic step();
      @(posedge clk_100MHz);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic serve_out(output int ticks);
      ticks = 0;
      frame_tick = 1'b1;
      ball_valid = 1'b0;
      for (int i = 0; i < int'(SF) + 5 && ball_freeze; i++) begin
         step();
         ticks++;
         if (BTN && ticks == int'(SF)) break;
      end
      frame_tick = 1'b0;
      if (BTN) begin
         step();
         chk("btn_wait_freeze", int'(ball_freeze), 1);
         pulse_start();
      end
   endtask

   task automatic goal(input logic [9:0] x);
      ball_x = x;
      ball_valid = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      ball_valid = 1'b0;
   endtask

   initial begin
      int t;
      int extra;
      reset = 1'b1; start = 1'b1; frame_tick = 1'b0; ball_valid = 1'b0; ball_x = 10'd320;
      step();
      cmp_en = 1'b1;
      step();
      chk("rst_freeze", int'(ball_freeze), 1);
      chk("rst_game_over", int'(game_over), 0);
      chk("rst_bcd_A", int'(score_A_bcd), 0);
      chk("rst_serve_dir", int'(serve_dir), 0);
      reset = 1'b0;

      // Start held through reset must not begin a serve.
      frame_tick = 1'b1;
      repeat (70) step();
      frame_tick = 1'b0;
      chk("held_start_idle", int'(ball_freeze), 1);
      start = 1'b0;
      step();

      pulse_start();
      serve_out(t);
      chk("serve_ticks", t, 60);
      chk("play_unfrozen", int'(ball_freeze), 0);

      ball_x = 10'd0; ball_valid = 1'b0; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("invalid_goal_B", int'(score_B), 0);

      goal(10'd1);
      chk("goal_B_pulse", int'(score_B), 1);
      chk("goal_B_no_A", int'(score_A), 0);
      chk("goal_B_freeze", int'(ball_freeze), 1);
      chk("goal_B_dir", int'(serve_dir), 0);
      chk("goal_B_bcd_pre", int'(score_B_bcd), 0);
      step();
      chk("goal_B_pulse_end", int'(score_B), 0);
      chk("goal_B_bcd_post", int'(score_B_bcd), 1);

      pulse_start();
      serve_out(t);
      chk("serve_ticks_reload", t, 60);

      goal(10'd639);
      chk("goal_A_pulse", int'(score_A), 1);
      reset = 1'b1;
      #1;
      chk("rst_point_pulse", int'(score_A), 0);
      chk("rst_point_bcd_B", int'(score_B_bcd), 0);
      step();
      reset = 1'b0;
      step();
      chk("rst_point_bcd_A", int'(score_A_bcd), 0);

      pulse_start();
      for (int k = 0; k < 3; k++) begin
         serve_out(t);
         goal(10'd639);
         step();
      end
      chk("win_bcd_A", int'(score_A_bcd), 3);
      chk("win_game_over", int'(game_over), 1);
      chk("win_winner", int'(winner), 0);
      extra = 0;
      for (int k = 0; k < 5; k++) begin
         goal(10'd639);
         extra += int'(score_A);
      end
      chk("over_no_extra_pulse", extra, 0);
      chk("over_bcd_A_hold", int'(score_A_bcd), 3);

      pulse_start();
      chk("restart_game_over", int'(game_over), 0);
      chk("restart_bcd_A", int'(score_A_bcd), 0);
      chk("restart_dir", int'(serve_dir), 0);
      serve_out(t);
      chk("restart_serve_ticks", t, 60);

      // Random play with occasional presses and resets.
      for (int c = 0; c < 6000; c++) begin
         frame_tick = ($urandom % 3) == 0;
         ball_valid = ($urandom % 4) != 0;
         case ($urandom % 8)
            0: ball_x = 10'd0;
            1: ball_x = 10'd2;
            2: ball_x = 10'd3;
            3: ball_x = 10'd636;
            4: ball_x = 10'd637;
            5: ball_x = 10'd1023;
            default: ball_x = 10'($urandom_range(3, 636));
         endcase
         if (($urandom % 25) == 0) start = ~start;
         reset = ($urandom % 1500) == 0;
         step();
      end
      reset = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
